// File: rtl/pc_sequencer_if.sv
// Handshake and bus bundle between the PC sequencer (master) and its surroundings:
// instruction memory, datapath and the PC block (slave).
interface pc_sequencer_if #(
  parameter int PC_W  = 12,
  parameter int OFF_W = 10
);
  logic             run;
  logic             imem_ack;
  logic             ex_done;
  logic             br_uncond;
  logic             br_cbz;
  logic             br_cbnz;
  logic             zero;
  logic             halt;
  logic [OFF_W-1:0] br_off;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             instr_valid;
  logic [PC_W-1:0]  new_inst;
  logic             pc_we;
  logic             busy;
  logic             fault;

  modport master (
    input  run, imem_ack, ex_done, br_uncond, br_cbz, br_cbnz, zero, halt, br_off,
    output imem_req, imem_addr, instr_valid, new_inst, pc_we, busy, fault
  );

  modport slave (
    output run, imem_ack, ex_done, br_uncond, br_cbz, br_cbnz, zero, halt, br_off,
    input  imem_req, imem_addr, instr_valid, new_inst, pc_we, busy, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle program counter sequencer: IDLE -> FETCH -> EXEC -> UPDATE.
// Optional macro PC_WRAP_TRAP_EN turns PC range overflow into a sticky fault instead of a silent wrap.
module pc_sequencer #(
  parameter int              PC_W      = 12,
  parameter int              OFF_W     = 10,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halt_q, halt_d;
  logic            fault_q, fault_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            pc_we_q, pc_we_d;
  logic            busy_q, busy_d;
  logic            taken_s;
  logic            wrap_s;
  logic [PC_W-1:0] next_pc_s;

  // Branch resolution: B beats CBZ beats CBNZ.
  always_comb begin
    taken_s = 1'b0;
    if (bus.br_uncond) begin
      taken_s = 1'b1;
    end else if (bus.br_cbz) begin
      taken_s = bus.zero;
    end else if (bus.br_cbnz) begin
      taken_s = !bus.zero;
    end else begin
      taken_s = 1'b0;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  localparam int SW = ((OFF_W + 2 > PC_W) ? OFF_W + 2 : PC_W) + 2;
  logic signed [SW-1:0] step_w_s;
  logic signed [SW-1:0] sum_w_s;

  // Next-PC adder kept wide enough to see any excursion outside 0..2^PC_W-1.
  always_comb begin
    step_w_s = SW'(4'sd4);
    if (taken_s) begin
      step_w_s = SW'($signed(bus.br_off)) <<< 2'd2;
    end else begin
      step_w_s = SW'(4'sd4);
    end
    sum_w_s   = $signed(SW'(pc_q)) + step_w_s;
    next_pc_s = sum_w_s[PC_W-1:0];
    wrap_s    = sum_w_s[SW-1] || (|sum_w_s[SW-2:PC_W]);
  end
`else
  logic [PC_W-1:0] step_s;

  // Next-PC adder wrapping modulo 2^PC_W.
  always_comb begin
    step_s = PC_W'(3'd4);
    if (taken_s) begin
      step_s = PC_W'($signed(bus.br_off)) << 2'd2;
    end else begin
      step_s = PC_W'(3'd4);
    end
    next_pc_s = pc_q + step_s;
    wrap_s    = 1'b0;
  end
`endif

  // Sequencing FSM; the PC is committed on entry to UPDATE so it is visible with pc_we.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run && !fault_q) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (bus.ex_done && wrap_s) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else if (bus.ex_done) begin
          pc_d    = next_pc_s;
          halt_d  = bus.halt;
          state_d = S_UPDATE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_UPDATE: begin
        if (halt_q) begin
          state_d = S_IDLE;
        end else if (bus.run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered, decoded from the state being entered.
  always_comb begin
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_q == S_FETCH) && (state_d == S_EXEC);
    pc_we_d       = (state_d == S_UPDATE);
    busy_d        = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VEC;
      halt_q        <= 1'b0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_we_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halt_q        <= halt_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      pc_we_q       <= pc_we_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.new_inst    = pc_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller that owns the program counter value and sequences its update.
- Drives the 12-bit newInst bus of the PC block.
- Handshakes instruction fetch with instruction memory and waits for the datapath to finish execution.
- Selects sequential (PC+4) or branch (PC + sign-extended offset × 4) next address for B, CBZ and CBNZ.

Parameters:
- PC_W, 12, width of PC, fetch address and newInst bus.
- OFF_W, 10, width of signed branch word offset.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- run  input  1  level; permits leaving IDLE and continuing after UPDATE.
- imem_ack  input  1  instruction memory has returned the word for imem_addr.
- ex_done  input  1  datapath finished the current instruction; branch inputs are valid this cycle.
- br_uncond  input  1  B instruction (always taken).
- br_cbz  input  1  CBZ instruction.
- br_cbnz  input  1  CBNZ instruction.
- zero  input  1  ALU zero flag for CBZ/CBNZ.
- halt  input  1  stop after this instruction.
- br_off  input  OFF_W  signed branch offset, in words.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address; equals the current PC.
- instr_valid  output  1  one-cycle pulse when a fetched word is accepted.
- new_inst  output  PC_W  next PC value; connects to the PC block's newInst.
- pc_we  output  1  one-cycle pulse; new_inst is the committed PC.
- busy  output  1  high in any state other than IDLE.
- fault  output  1  trap flag (see Optional Feature).

Behaviour:
- Reset (reset=0 at rising edge):
  - state=IDLE, PC=RESET_VEC, new_inst=RESET_VEC.
  - imem_req, instr_valid, pc_we, busy and fault are all 0.
  - Reset overrides every other input.
  - A reset during FETCH, EXEC or UPDATE aborts the operation; no pc_we is issued.
- States and transitions:
  - IDLE: go to FETCH when run=1.
  - FETCH: imem_req=1 and imem_addr=PC, both held stable until imem_ack=1 is seen on a rising edge. Then go to EXEC and pulse instr_valid=1 during the first EXEC cycle.
  - EXEC: imem_req=0. Wait for ex_done=1. At that edge capture the next-PC decision and the halt flag, then go to UPDATE.
  - UPDATE: pc_we=1 for exactly one cycle, with new_inst = PC = captured next value. Then:
    - if captured halt=1, go to IDLE;
    - else if run=1, go to FETCH;
    - else go to IDLE.
- Next-PC selection, evaluated at the ex_done edge:
  - If br_uncond=1, branch is taken.
  - Else if br_cbz=1, taken when zero=1.
  - Else if br_cbnz=1, taken when zero=0.
  - Otherwise not taken.
  - br_uncond has priority over br_cbz, and br_cbz over br_cbnz, when several are asserted together.
- Arithmetic:
  - Taken: PC + (sign-extended br_off << 2), truncated to PC_W bits (modulo 2^PC_W).
  - Not taken: PC + 4, modulo 2^PC_W; 0xFFC wraps to 0x000.
  - The PC stays word-aligned: bits [1:0] are always 0 once RESET_VEC is aligned.
- Inputs are ignored outside their own state:
  - imem_ack is ignored outside FETCH.
  - ex_done and the branch inputs are ignored outside EXEC.
- new_inst changes only in UPDATE or on reset.
- Latency: minimum 3 cycles per instruction, when imem_ack and ex_done are each high on their first cycle. Each extra wait cycle adds one.
- Dropping run while busy: the current instruction completes; the sequencer stops in IDLE after UPDATE.

Optional Feature:
- Macro: PC_WRAP_TRAP_EN.
- Defined:
  - At the ex_done edge, if the selected next-PC computation overflows or underflows the PC_W range, the following happens:
    - fault is set to 1;
    - the UPDATE cycle is skipped, so pc_we is not pulsed;
    - PC is unchanged;
    - the sequencer goes to IDLE and stays there until reset, ignoring run.
  - The trap applies to the wrap of PC+4 and to a taken branch outside the range 0..2^PC_W-4.
  - fault is cleared only by reset.
- Undefined: arithmetic wraps silently as specified above, and fault is tied to 0.

Test Plan:
- Reset then run=1; imem_ack and ex_done held high; no branches:
  - pc_we pulses every 3 cycles;
  - new_inst sequence is 0x004, 0x008, 0x00C;
  - imem_addr sequence is 0x000, 0x004, 0x008.
- Fetch stall: PC=0x010, imem_ack delayed 4 cycles:
  - imem_req and imem_addr=0x010 are held stable for those 4 cycles;
  - instr_valid pulses exactly once;
  - the next pc_we gives 0x014.
- Branches from PC=0x100:
  - br_uncond with br_off=-4 (0x3FC) gives new_inst=0x0F0;
  - br_cbz with zero=1 and br_off=8 gives 0x120;
  - br_cbz with zero=0 gives 0x104;
  - br_cbnz with zero=0 and br_off=2 gives 0x108.
- Wrap at PC=0xFFC, no branch:
  - macro undefined: new_inst=0x000 and fault=0;
  - macro defined: fault=1, no pc_we, state IDLE, PC stays 0xFFC.
- Reset mid-operation and halt:
  - reset=0 during EXEC gives PC=RESET_VEC next cycle with no pc_we;
  - halt=1 with ex_done gives one pc_we, then busy=0 while run stays 1.
